irq_core_handshake: RTL and testbench



---
 rtl/irq_core_handshake_pkg.sv | 14 +
 rtl/irq_core_handshake_if.sv | 27 ++
 rtl/irq_core_handshake_prio_enc.sv | 18 +
 rtl/irq_core_handshake.sv | 127 ++++++++++++
 tb/tb_irq_core_handshake.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/irq_core_handshake_pkg.sv
// Shared types and defaults for the core-side irq handshake.
// Holds the FSM state enum, the default ID width and the default clear timeout.
package event_unit_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_CLEAR = 2'd2
    } irq_hs_state_e;

    localparam int IRQ_ID_WIDTH       = 5;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/irq_core_handshake_if.sv
// Request/acknowledge bundle between the irq handshake stage and the core.
// master: drives irq_req_o, irq_id_o, ack_err_o. slave: drives irq_ack_i, irq_ack_id_i.
interface irq_core_handshake_if #(
    parameter int ID_WIDTH = 5
);
    logic                irq_req_o;
    logic [ID_WIDTH-1:0] irq_id_o;
    logic                ack_err_o;
    logic                irq_ack_i;
    logic [ID_WIDTH-1:0] irq_ack_id_i;

    modport master (
        output irq_req_o,
        output irq_id_o,
        output ack_err_o,
        input  irq_ack_i,
        input  irq_ack_id_i
    );

    modport slave (
        input  irq_req_o,
        input  irq_id_o,
        input  ack_err_o,
        output irq_ack_i,
        output irq_ack_id_i
    );
endinterface

// File: rtl/irq_core_handshake_prio_enc.sv
// Lowest-index-wins priority encoder for the irq vector.
// Ports: irq (vector in), id (winning index), valid (any bit set).
module irq_prio_enc #(
    parameter int NUM_IRQ  = 32,
    parameter int ID_WIDTH = 5
) (
    input  logic [NUM_IRQ-1:0]  irq,
    output logic [ID_WIDTH-1:0] id,
    output logic                valid
);
    always_comb begin
        id    = '0;
        valid = |irq;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) id = ID_WIDTH'(i);
        end
    end
endmodule

// File: rtl/irq_core_handshake.sv
// Presents one irq request plus ID to the core with a req/ack handshake,
// blocks re-request until the pending bit clears, and registers a wake-up.
// Ports: HCLK, HRESETn, irq_i, core_sleeping_i, hs (master), wakeup_o, busy_o.
// Optional: IRQ_CLEAR_TIMEOUT_EN bounds the WAIT_CLEAR stay by TIMEOUT_CYCLES.
module irq_core_handshake
    import event_unit_pkg::*;
#(
    parameter int NUM_IRQ        = 32,
    parameter int ID_WIDTH       = IRQ_ID_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               core_sleeping_i,
    irq_core_handshake_if.master hs,
    output logic               wakeup_o,
    output logic               busy_o
);
    if (NUM_IRQ < 2 || NUM_IRQ > 32) begin : g_bad_num_irq
        $error("irq_core_handshake: NUM_IRQ out of range");
    end
    if (ID_WIDTH < 1 || ID_WIDTH != $clog2(NUM_IRQ)) begin : g_bad_id_w
        $error("irq_core_handshake: ID_WIDTH must be clog2(NUM_IRQ)");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("irq_core_handshake: TIMEOUT_CYCLES below 2");
    end

    irq_hs_state_e       state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                req_q, err_q, err_d;
    logic                wake_q, busy_q;
    logic [ID_WIDTH-1:0] enc_id;
    logic                enc_valid;
    logic                cur_bit;
    logic                ack_hit;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_enc (
        .irq  (irq_i),
        .id   (enc_id),
        .valid(enc_valid)
    );

    // id_q never holds an index >= NUM_IRQ, so equality also rejects
    // out-of-range acknowledge IDs.
    assign cur_bit = irq_i[id_q];
    assign ack_hit = hs.irq_ack_i && (hs.irq_ack_id_i == id_q);

`ifdef IRQ_CLEAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // Zero outside WAIT_CLEAR, so it starts from 0 on every entry.
    assign cnt_d = (state_q == WAIT_CLEAR) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs.irq_ack_i) err_d = 1'b1;
                if (enc_valid) begin
                    state_d = REQ;
                    id_d    = enc_id;
                end
            end
            REQ: begin
                // A matching ack beats a simultaneous withdraw.
                if (ack_hit) begin
                    state_d = WAIT_CLEAR;
                end else begin
                    if (hs.irq_ack_i) err_d = 1'b1;
                    if (!cur_bit) state_d = IDLE;
                end
            end
            WAIT_CLEAR: begin
                if (hs.irq_ack_i) err_d = 1'b1;
                if (!cur_bit) begin
                    state_d = IDLE;
`ifdef IRQ_CLEAR_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            wake_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= (state_d == REQ);
            err_q   <= err_d;
            wake_q  <= core_sleeping_i & (|irq_i);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign hs.irq_req_o = req_q;
    assign hs.irq_id_o  = id_q;
    assign hs.ack_err_o = err_q;
    assign wakeup_o     = wake_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_irq_core_handshake.sv
// Directed self-checking bench for irq_core_handshake.
// Build with IRQ_CLEAR_TIMEOUT_EN defined to also cover the clear timeout.
module tb_irq_core_handshake;
`ifdef IRQ_CLEAR_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] irq_i = '0;
    logic        core_sleeping_i = 1'b0;
    logic        wakeup_o;
    logic        busy_o;
    int          n_tests = 0;
    int          n_fail = 0;

    irq_core_handshake_if #(.ID_WIDTH(5)) hs ();

    irq_core_handshake #(
        .NUM_IRQ       (32),
        .ID_WIDTH      (5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .irq_i          (irq_i),
        .core_sleeping_i(core_sleeping_i),
        .hs             (hs),
        .wakeup_o       (wakeup_o),
        .busy_o         (busy_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic a, input logic [4:0] id);
        hs.irq_ack_i    = a;
        hs.irq_ack_id_i = id;
    endtask

    initial begin
        ack(1'b0, 5'd0);
        irq_i = 32'h0000_0010;
        tick();
        tick();
        chk("rst_req", 32'(hs.irq_req_o), 0);
        chk("rst_id", 32'(hs.irq_id_o), 0);
        chk("rst_err", 32'(hs.ack_err_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_wake", 32'(wakeup_o), 0);
        HRESETn = 1'b1;
        tick();
        chk("rel_req", 32'(hs.irq_req_o), 1);
        chk("rel_id", 32'(hs.irq_id_o), 4);
        chk("rel_busy", 32'(busy_o), 1);
        irq_i = 32'h0;
        tick();
        chk("rel_wd_busy", 32'(busy_o), 0);

        // ack then wait for clear, other bit held off
        irq_i = 32'h0000_0300;
        tick();
        chk("t2_req", 32'(hs.irq_req_o), 1);
        chk("t2_id", 32'(hs.irq_id_o), 8);
        ack(1'b1, 5'd8);
        tick();
        ack(1'b0, 5'd0);
        chk("t2_ack_req", 32'(hs.irq_req_o), 0);
        chk("t2_ack_busy", 32'(busy_o), 1);
        chk("t2_ack_err", 32'(hs.ack_err_o), 0);
        tick();
        chk("t2_hold_req", 32'(hs.irq_req_o), 0);
        chk("t2_hold_busy", 32'(busy_o), 1);
        irq_i = 32'h0;
        tick();
        chk("t2_clr_busy", 32'(busy_o), 0);

        // mismatched ack, no preemption
        irq_i = 32'h0000_0100;
        tick();
        ack(1'b1, 5'd9);
        tick();
        ack(1'b0, 5'd0);
        chk("t3_err", 32'(hs.ack_err_o), 1);
        chk("t3_req", 32'(hs.irq_req_o), 1);
        chk("t3_id", 32'(hs.irq_id_o), 8);
        irq_i = 32'h0000_0101;
        tick();
        chk("t3_err_end", 32'(hs.ack_err_o), 0);
        chk("t3_nopre_id", 32'(hs.irq_id_o), 8);
        irq_i = 32'h0;
        tick();
        chk("t3_wd_req", 32'(hs.irq_req_o), 0);

        // withdraw without ack
        irq_i = 32'h0000_0008;
        tick();
        chk("t4_id", 32'(hs.irq_id_o), 3);
        irq_i = 32'h0;
        tick();
        chk("t4_req", 32'(hs.irq_req_o), 0);
        chk("t4_busy", 32'(busy_o), 0);

        // ack and withdraw together
        irq_i = 32'h0000_0008;
        tick();
        irq_i = 32'h0;
        ack(1'b1, 5'd3);
        tick();
        ack(1'b0, 5'd0);
        chk("t5_wc_busy", 32'(busy_o), 1);
        chk("t5_wc_req", 32'(hs.irq_req_o), 0);
        tick();
        chk("t5_idle", 32'(busy_o), 0);
        ack(1'b1, 5'd0);
        tick();
        chk("t5_idle_ackerr", 32'(hs.ack_err_o), 1);
        ack(1'b0, 5'd0);
        irq_i = 32'h1;
        tick();
        chk("t5_new_req", 32'(hs.irq_req_o), 1);
        chk("t5_new_id", 32'(hs.irq_id_o), 0);
        chk("t5_err_end", 32'(hs.ack_err_o), 0);
        ack(1'b1, 5'd0);
        tick();
        tick();
        chk("t5_wc_ackerr", 32'(hs.ack_err_o), 1);
        chk("t5_wc_busy2", 32'(busy_o), 1);
        ack(1'b0, 5'd0);
        irq_i = 32'h0;
        tick();
        chk("t5_done", 32'(busy_o), 0);

        // wake-up
        core_sleeping_i = 1'b1;
        tick();
        chk("t6_wake0", 32'(wakeup_o), 0);
        irq_i = 32'h8000_0000;
        tick();
        chk("t6_wake1", 32'(wakeup_o), 1);
        chk("t6_id31", 32'(hs.irq_id_o), 31);
        core_sleeping_i = 1'b0;
        tick();
        chk("t6_wake_off", 32'(wakeup_o), 0);
        irq_i = 32'h0;
        tick();
        chk("t6_idle", 32'(busy_o), 0);

`ifdef IRQ_CLEAR_TIMEOUT_EN
        irq_i = 32'h0000_0004;
        tick();
        ack(1'b1, 5'd2);
        tick();
        ack(1'b0, 5'd0);
        chk("to_enter", 32'(busy_o), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_err", 32'(hs.ack_err_o), 0);
        end
        tick();
        chk("to_err", 32'(hs.ack_err_o), 1);
        chk("to_idle", 32'(busy_o), 0);
        tick();
        chk("to_rereq", 32'(hs.irq_req_o), 1);
        chk("to_reid", 32'(hs.irq_id_o), 2);
        irq_i = 32'h0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
